demux_rr_dispatcher: RTL



---
 rtl/demux_rr_dispatcher.sv | 133 +++++++++++++
 1 files changed

// File: rtl/demux_rr_dispatcher.sv
// demux_rr_dispatcher: one-item holding stage that hands a single upstream
// valid/ready stream to one of N consumer channels, picked either round-robin
// or by an explicit select sampled when the item is accepted.
module demux_rr_dispatcher #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned N     = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mode,
   input  logic [$clog2(N)-1:0]  sel,
   input  logic [WIDTH-1:0]      in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [N-1:0]          out_valid,
   input  logic [N-1:0]          out_ready,
   output logic [$clog2(N)-1:0]  rr_ptr,
   output logic [15:0]           sent_count,
   output logic                  err_drop
);

   localparam int unsigned SW = $clog2(N);
   localparam int unsigned CW = 16;

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_HOLD  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [N-1:0]     valid_q, valid_d;
   logic [SW-1:0]    rr_q, rr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             err_q, err_d;

   logic             fire_c;
   logic             accept_c;
   logic [SW-1:0]    dest_c;
   logic             dest_ok_c;
   logic [N-1:0]     onehot_c;

   // Handshake decode: delivery, acceptance and destination of the incoming item
   always_comb begin
      fire_c    = |(valid_q & out_ready);
      in_ready  = ~rst & ((state_q == S_EMPTY) | fire_c);
      accept_c  = in_valid & in_ready;
      dest_c    = mode ? sel : rr_q;
      // Only reachable as false when N is not a power of two
      dest_ok_c = ({1'b0, dest_c} < (SW+1)'(N));
      onehot_c  = N'(1) << dest_c;
   end

   // Next-state, holding register, pointer, counter and drop pulse
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      valid_d = valid_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;

      if (fire_c) begin
         cnt_d = cnt_q + CW'(1);
      end

      // Pointer advances on every round-robin accept, dropped or not
      if (accept_c && !mode) begin
         rr_d = (rr_q == SW'(N - 1)) ? '0 : rr_q + SW'(1);
      end

      case (state_q)
         S_EMPTY: begin
            if (accept_c) begin
               data_d = in_data;
               if (dest_ok_c) begin
                  state_d = S_HOLD;
                  valid_d = onehot_c;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_HOLD: begin
            // In HOLD an accept can only happen together with a fire
            if (accept_c) begin
               data_d = in_data;
               if (dest_ok_c) begin
                  valid_d = onehot_c;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_EMPTY;
                  valid_d = '0;
               end
            end else if (fire_c) begin
               state_d = S_EMPTY;
               valid_d = '0;
            end
         end
         default: begin
            state_d = S_EMPTY;
            valid_d = '0;
         end
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_EMPTY;
         data_q  <= '0;
         valid_q <= '0;
         rr_q    <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign out_data   = data_q;
   assign out_valid  = valid_q;
   assign rr_ptr     = rr_q;
   assign sent_count = cnt_q;
   assign err_drop   = err_q;

endmodule
